act_buf_reader: RTL and testbench
=================================

# act_buf_reader

Activation-fetch engine on the input side of the core. It walks a feature-map tile stored in the activation buffer, issues reads to that buffer's read port, and absorbs the fixed read latency. Each word is returned to the core's activation input with its pixel row/column tag, under a valid/ready handshake. It is the read-side counterpart of the result saver, consuming buffers laid out by the write path.

## Interface
- ADDR_W, 10, buffer word-address width
- DW, 256, buffer word / activation width in bits
- READ_LAT, 2, buffer read latency in cycles (enable at cycle n → data valid at n+READ_LAT)
- FIFO_DEPTH, 4, output skid FIFO entries; must be ≥ READ_LAT+1

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle job start; descriptor latched this cycle
- i_base_addr  in  ADDR_W  first word address of tile
- i_num_rows  in  9  rows in tile
- i_num_cols  in  9  words per row
- i_row_stride  in  ADDR_W  address step between rows
- i_repeat  in  4  extra replays of each row (0 = each row once)
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse at job end
- buf_enb  out  1  buffer read enable
- buf_addrb  out  ADDR_W  buffer read address
- buf_doutb  in  DW  buffer read data
- o_Act  out  DW  activation word to core
- o_row  out  9  row index of o_Act
- o_col  out  9  column index of o_Act
- o_Vld  out  1  o_Act/o_row/o_col valid
- i_Ready  in  1  core accepts; transfer when o_Vld & i_Ready

## Operation
- States: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: i_start latches the descriptor and enters ISSUE. o_busy=1 from the next cycle.
- If i_num_rows=0 or i_num_cols=0, go straight to IDLE with o_done pulsed the cycle after start. No reads are issued.
- i_start while o_busy is ignored; the descriptor is held.
- Issue order: for r in 0..rows-1, for p in 0..i_repeat, for c in 0..cols-1.
  - addr = base + r*row_stride + c, modulo 2^ADDR_W (wrap, no error).
  - Row base is kept as a running sum, with no multiplier.
- Credit rule: issue one read (buf_enb=1) in a cycle only if outstanding_reads + fifo_count < FIFO_DEPTH.
  - outstanding_reads counts reads issued but not yet written to the FIFO.
  - This guarantees the FIFO never overflows and never drops data.
- Tag pipeline: {r,c} is delayed READ_LAT cycles beside the enable. At arrival, {buf_doutb, r, c} is written into the FIFO.
- FIFO is show-ahead: o_Vld = !empty, and o_Act/o_row/o_col come from the head entry.
- Simultaneous FIFO write and pop is allowed at any occupancy, including full and empty. When full, a pop frees a slot for a write in the same cycle.
- ISSUE → DRAIN after the last address is issued. DRAIN → IDLE on the transfer of the final word.
  - o_done=1 for the following cycle, o_busy=0 in the same cycle.
- Reset in mid-job clears state, counters, tag pipeline and FIFO. Read data still in flight from the buffer is discarded.

## Timing
- Reset values: o_busy=0, o_done=0, buf_enb=0, buf_addrb=0, o_Vld=0, o_Act=0, o_row=0, o_col=0.
- Start at cycle t → first buf_enb at t+1 → data captured into FIFO at t+1+READ_LAT → o_Vld at t+2+READ_LAT (t+4 at default).
- With i_Ready held at 1, throughput is one word per cycle with no bubbles. Total job ≈ rows*(repeat+1)*cols + READ_LAT + 3 cycles.
- i_Ready low: issue stops once credit is exhausted. o_Act and tags are held stable while o_Vld & !i_Ready.
- o_done occurs exactly one cycle after the last accepted transfer.

## Test plan
- Basic tile: base=0x010, rows=2, cols=3, stride=0x020, repeat=0, i_Ready=1.
  - Required: addresses 0x010,0x011,0x012,0x030,0x031,0x032 on consecutive cycles.
  - First o_Vld at t+4, six transfers with tags (0,0)…(1,2) in that order, o_done at the cycle after the 6th.
- Repeat: rows=1, cols=2, repeat=2.
  - Required: addresses 0x010,0x011 issued three times; tags (0,0),(0,1) three times; 6 transfers.
- Backpressure: i_Ready toggles 1,0,0,1,… over the basic tile.
  - Required: no lost or duplicated words; outputs stable while stalled.
  - FIFO occupancy + outstanding never exceeds 4; buf_enb drops when credit is out.
- Wrap: base=0x3FE, cols=4.
  - Required: addresses 0x3FE,0x3FF,0x000,0x001.
- Zero-size and re-start:
  - rows=0 → o_done at t+1, no buf_enb.
  - i_start pulsed mid-job → ignored; the sequence is unchanged.
- Reset mid-job: assert RST during DRAIN with 3 words buffered.
  - Required: next cycle all outputs are at reset values.
  - Later buf_doutb arrivals produce no o_Vld.
  - A new job then runs correctly.

Source files
------------

// File: rtl/act_buf_reader.sv
// Activation-fetch engine: walks a tile in the activation buffer, absorbs the read
// latency and returns tagged words to the core through a credit-limited skid FIFO.
//
// state  | meaning
// IDLE   | waiting for i_start
// ISSUE  | issuing buffer reads while credit allows
// DRAIN  | all reads issued, waiting for the final word to transfer
module act_buf_reader #(
  parameter int ADDR_W     = 10,
  parameter int DW         = 256,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [8:0]        i_num_rows,
  input  logic [8:0]        i_num_cols,
  input  logic [ADDR_W-1:0] i_row_stride,
  input  logic [3:0]        i_repeat,
  output logic              o_busy,
  output logic              o_done,
  output logic              buf_enb,
  output logic [ADDR_W-1:0] buf_addrb,
  input  logic [DW-1:0]     buf_doutb,
  output logic [DW-1:0]     o_Act,
  output logic [8:0]        o_row,
  output logic [8:0]        o_col,
  output logic              o_Vld,
  input  logic              i_Ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DW + 18;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] stride_q, row_base;
  logic [8:0]        rows_q, cols_q, r_cnt, c_cnt;
  logic [3:0]        rep_q, p_cnt;
  logic [CW-1:0]     outstanding, fifo_count;
  logic              done_q, done_nxt;

  logic [READ_LAT-1:0] vld_pipe;
  logic [8:0]          row_pipe [READ_LAT];
  logic [8:0]          col_pipe [READ_LAT];

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic          start_ok, zero_size, credit_ok, issue, last_issue;
  logic          fifo_wr, fifo_pop, fifo_empty, final_xfer;
  logic [CW:0]   credit_used;

  assign zero_size   = (i_num_rows == '0) || (i_num_cols == '0);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < DEPTH_C;
  assign last_issue  = (c_cnt == cols_q - 9'd1) && (p_cnt == rep_q) &&
                       (r_cnt == rows_q - 9'd1);
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_wr     = vld_pipe[READ_LAT-1];
  assign fifo_pop    = !fifo_empty && i_Ready;
  // Nothing in flight and one word left means this pop ends the job.
  assign final_xfer  = fifo_pop && (fifo_count == CW'(1)) && (outstanding == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          start_ok = 1'b1;
          if (zero_size) done_nxt = 1'b1;
          else state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_issue) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (final_xfer) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row base is a running sum of the stride; address wraps at 2^ADDR_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rows_q   <= '0;
      cols_q   <= '0;
      rep_q    <= '0;
      stride_q <= '0;
      row_base <= '0;
      r_cnt    <= '0;
      p_cnt    <= '0;
      c_cnt    <= '0;
    end else if (start_ok) begin
      rows_q   <= i_num_rows;
      cols_q   <= i_num_cols;
      rep_q    <= i_repeat;
      stride_q <= i_row_stride;
      row_base <= i_base_addr;
      r_cnt    <= '0;
      p_cnt    <= '0;
      c_cnt    <= '0;
    end else if (issue) begin
      if (c_cnt == cols_q - 9'd1) begin
        c_cnt <= '0;
        if (p_cnt == rep_q) begin
          p_cnt    <= '0;
          r_cnt    <= r_cnt + 9'd1;
          row_base <= row_base + stride_q;
        end else begin
          p_cnt <= p_cnt + 4'd1;
        end
      end else begin
        c_cnt <= c_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        row_pipe[i] <= '0;
        col_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= issue;
      row_pipe[0] <= r_cnt;
      col_pipe[0] <= c_cnt;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      fifo_count  <= fifo_count + CW'(fifo_wr) - CW'(fifo_pop);
      outstanding <= outstanding + CW'(issue) - CW'(fifo_wr);
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {buf_doutb, row_pipe[READ_LAT-1], col_pipe[READ_LAT-1]};
  end

  assign o_busy    = (state != S_IDLE);
  assign o_done    = done_q;
  assign buf_enb   = issue;
  assign buf_addrb = issue ? (row_base + ADDR_W'(c_cnt)) : '0;
  assign o_Vld     = !fifo_empty;
  assign {o_Act, o_row, o_col} = fifo_empty ? '0 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_act_buf_reader.sv
// Bench for act_buf_reader: random tiles and backpressure checked every cycle against
// a queue-based model of issue order, credit limit, latency and job completion.
module tb_act_buf_reader;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         i_start;
  logic [9:0]   i_base_addr;
  logic [8:0]   i_num_rows, i_num_cols;
  logic [9:0]   i_row_stride;
  logic [3:0]   i_repeat;
  logic         o_busy, o_done, buf_enb, o_Vld, i_Ready;
  logic [9:0]   buf_addrb;
  logic [255:0] buf_doutb, o_Act;
  logic [8:0]   o_row, o_col;

  act_buf_reader dut (
    .CLK(CLK), .RST(RST), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_rows(i_num_rows), .i_num_cols(i_num_cols), .i_row_stride(i_row_stride),
    .i_repeat(i_repeat), .o_busy(o_busy), .o_done(o_done), .buf_enb(buf_enb),
    .buf_addrb(buf_addrb), .buf_doutb(buf_doutb), .o_Act(o_Act), .o_row(o_row),
    .o_col(o_col), .o_Vld(o_Vld), .i_Ready(i_Ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Buffer with fixed two-cycle read latency; junk on idle cycles.
  logic [255:0] bmem [1024];
  logic [1:0]   e_pipe = '0;
  logic [9:0]   a_pipe0 = '0, a_pipe1 = '0;
  always @(posedge CLK) begin
    e_pipe  <= {e_pipe[0], buf_enb};
    a_pipe0 <= buf_addrb;
    a_pipe1 <= a_pipe0;
  end
  assign buf_doutb = e_pipe[1] ? bmem[a_pipe1] : {8{32'hDEADBEEF}};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int cyc; int a; int b;} ev_t;
  typedef struct {logic [255:0] d; int r; int c;} word_t;
  ev_t   enb_log[$], xfer_log[$];
  int    done_log[$];
  word_t outq[$];
  int    addrq[$];
  int    arr[$];
  int    issued, xfers, inflight, wa;
  logic  exp_busy = 1'b0, exp_done = 1'b0, nxt_busy, nxt_done, exp_vld, exp_enb;
  logic  stall_prev = 1'b0;
  logic [255:0] prev_act;
  logic [8:0]   prev_row, prev_col;
  word_t w;

  // Reference model and per-cycle compare.
  always @(negedge CLK) begin
    if (RST) begin
      outq.delete(); addrq.delete(); arr.delete();
      issued = 0; xfers = 0;
      exp_busy = 1'b0; exp_done = 1'b0; stall_prev = 1'b0;
    end else begin
      inflight = issued - xfers;
      exp_vld  = (arr.size() > 0) && (arr[0] <= cyc);
      exp_enb  = (addrq.size() > 0) && (inflight < DEP);
      chk("busy", o_busy, exp_busy);
      chk("done", o_done, exp_done);
      chk("vld", o_Vld, exp_vld);
      chk("enb", buf_enb, exp_enb);
      if (stall_prev) begin
        chk("stall_vld", o_Vld, 1'b1);
        chk("stall_act", o_Act, prev_act);
        chk("stall_tag", {o_row, o_col}, {prev_row, prev_col});
      end
      stall_prev = o_Vld && !i_Ready;
      prev_act = o_Act; prev_row = o_row; prev_col = o_col;
      if (buf_enb) enb_log.push_back('{cyc, int'(buf_addrb), 0});
      if (o_Vld && i_Ready) xfer_log.push_back('{cyc, int'(o_row), int'(o_col)});
      if (o_done) done_log.push_back(cyc);

      nxt_done = 1'b0;
      nxt_busy = exp_busy;
      if (exp_enb) begin
        chk("addr", buf_addrb, addrq[0]);
        void'(addrq.pop_front());
        arr.push_back(cyc + LAT + 1);
        issued++;
      end
      if (exp_vld && i_Ready) begin
        w = outq.pop_front();
        void'(arr.pop_front());
        chk("act", o_Act, w.d);
        chk("tag", {o_row, o_col}, {w.r[8:0], w.c[8:0]});
        xfers++;
        if (outq.size() == 0) begin
          nxt_busy = 1'b0;
          nxt_done = 1'b1;
        end
      end
      if (i_start && !exp_busy) begin
        if (i_num_rows == 0 || i_num_cols == 0) begin
          nxt_done = 1'b1;
        end else begin
          for (int r = 0; r < int'(i_num_rows); r++)
            for (int p = 0; p <= int'(i_repeat); p++)
              for (int c = 0; c < int'(i_num_cols); c++) begin
                wa = (int'(i_base_addr) + r * int'(i_row_stride) + c) % 1024;
                addrq.push_back(wa);
                outq.push_back('{bmem[wa], r, c});
              end
          nxt_busy = 1'b1;
        end
      end
      exp_busy = nxt_busy;
      exp_done = nxt_done;
    end
  end

  // 0: always ready, 1: 1,0,0 pattern, 2: random, 3: never ready
  int ready_mode = 0;
  initial begin
    i_Ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0: i_Ready = 1'b1;
        1: i_Ready = (cyc % 3) == 0;
        2: i_Ready = $urandom_range(0, 2) != 0;
        default: i_Ready = 1'b0;
      endcase
    end
  end

  task automatic clear_logs();
    enb_log.delete(); xfer_log.delete(); done_log.delete();
  endtask

  task automatic start_job(input logic [9:0] base, input logic [8:0] rows, input logic [8:0] cols,
                           input logic [9:0] stride, input logic [3:0] rep, output int t);
    @(posedge CLK); #1;
    i_base_addr = base; i_num_rows = rows; i_num_cols = cols;
    i_row_stride = stride; i_repeat = rep; i_start = 1'b1;
    t = cyc;
    @(posedge CLK); #1;
    i_start = 1'b0;
    i_base_addr = 10'($urandom); i_num_rows = 9'($urandom); i_num_cols = 9'($urandom);
    i_row_stride = 10'($urandom); i_repeat = 4'($urandom);
  endtask

  // Optionally pulses i_start while the job is busy; those pulses must be ignored.
  task automatic wait_idle(input int maxc, input bit poke);
    int n = 0;
    while ((exp_busy || exp_done) && n < maxc) begin
      if (poke && exp_busy && $urandom_range(0, 5) == 0) begin
        i_base_addr = 10'($urandom); i_num_rows = 9'($urandom_range(1, 3));
        i_num_cols = 9'($urandom_range(1, 3)); i_start = 1'b1;
      end
      @(posedge CLK); #1;
      i_start = 1'b0;
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL timeout: job still busy after %0d cycles, required idle", n);
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  int t;
  int ea[6];
  int er[6];
  int ec[6];

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int j = 0; j < 8; j++) bmem[i][j*32 +: 32] = $urandom;
    RST = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_rows = '0; i_num_cols = '0;
    i_row_stride = '0; i_repeat = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out", {o_busy, o_done, buf_enb, buf_addrb, o_Vld}, '0);
    chk("rst_data", {o_Act, o_row, o_col}, '0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Basic tile
    ea = '{'h010, 'h011, 'h012, 'h030, 'h031, 'h032};
    er = '{0, 0, 0, 1, 1, 1};
    ec = '{0, 1, 2, 0, 1, 2};
    clear_logs();
    start_job(10'h010, 9'd2, 9'd3, 10'h020, 4'd0, t);
    wait_idle(100, 1'b0);
    chk("basic_nenb", enb_log.size(), 6);
    for (int i = 0; i < 6 && i < enb_log.size(); i++) begin
      chk("basic_addr", enb_log[i].a, ea[i]);
      chk("basic_addr_cyc", enb_log[i].cyc, t + 1 + i);
    end
    chk("basic_nxfer", xfer_log.size(), 6);
    for (int i = 0; i < 6 && i < xfer_log.size(); i++) begin
      chk("basic_tag", {xfer_log[i].a, xfer_log[i].b}, {er[i], ec[i]});
      chk("basic_xfer_cyc", xfer_log[i].cyc, t + 4 + i);
    end
    chk("basic_ndone", done_log.size(), 1);
    if (done_log.size() > 0) chk("basic_done_cyc", done_log[0], t + 10);

    // Repeat
    ea = '{'h010, 'h011, 'h010, 'h011, 'h010, 'h011};
    clear_logs();
    start_job(10'h010, 9'd1, 9'd2, 10'h020, 4'd2, t);
    wait_idle(100, 1'b0);
    chk("rep_nenb", enb_log.size(), 6);
    chk("rep_nxfer", xfer_log.size(), 6);
    for (int i = 0; i < 6 && i < enb_log.size(); i++) chk("rep_addr", enb_log[i].a, ea[i]);
    for (int i = 0; i < 6 && i < xfer_log.size(); i++)
      chk("rep_tag", {xfer_log[i].a, xfer_log[i].b}, {32'd0, i % 2});

    // Backpressure on basic tile
    ea = '{'h010, 'h011, 'h012, 'h030, 'h031, 'h032};
    ready_mode = 1;
    clear_logs();
    start_job(10'h010, 9'd2, 9'd3, 10'h020, 4'd0, t);
    wait_idle(200, 1'b0);
    chk("bp_nxfer", xfer_log.size(), 6);
    for (int i = 0; i < 6 && i < xfer_log.size(); i++)
      chk("bp_tag", {xfer_log[i].a, xfer_log[i].b}, {er[i], ec[i]});
    ready_mode = 0;

    // Wrap
    ea = '{'h3FE, 'h3FF, 'h000, 'h001, 0, 0};
    clear_logs();
    start_job(10'h3FE, 9'd1, 9'd4, 10'h000, 4'd0, t);
    wait_idle(100, 1'b0);
    chk("wrap_nenb", enb_log.size(), 4);
    for (int i = 0; i < 4 && i < enb_log.size(); i++) chk("wrap_addr", enb_log[i].a, ea[i]);

    // Zero size
    clear_logs();
    start_job(10'h010, 9'd0, 9'd3, 10'h020, 4'd0, t);
    wait_idle(20, 1'b0);
    chk("zero_nenb", enb_log.size(), 0);
    chk("zero_ndone", done_log.size(), 1);
    if (done_log.size() > 0) chk("zero_done_cyc", done_log[0], t + 1);
    clear_logs();
    start_job(10'h010, 9'd2, 9'd0, 10'h020, 4'd0, t);
    wait_idle(20, 1'b0);
    chk("zcol_nenb", enb_log.size(), 0);

    // Start pulsed mid-job is ignored
    ea = '{'h010, 'h011, 'h012, 'h030, 'h031, 'h032};
    clear_logs();
    start_job(10'h010, 9'd2, 9'd3, 10'h020, 4'd0, t);
    @(posedge CLK); #1;
    i_base_addr = 10'h200; i_num_rows = 9'd1; i_num_cols = 9'd1; i_start = 1'b1;
    @(posedge CLK); #1;
    i_start = 1'b0;
    wait_idle(100, 1'b0);
    chk("restart_nenb", enb_log.size(), 6);
    for (int i = 0; i < 6 && i < enb_log.size(); i++) chk("restart_addr", enb_log[i].a, ea[i]);

    // Reset during DRAIN with three words buffered
    ready_mode = 3;
    clear_logs();
    start_job(10'h100, 9'd1, 9'd4, 10'h000, 4'd0, t);
    repeat (5) @(posedge CLK);
    #1;
    chk("rstmid_nenb", enb_log.size(), 4);
    chk("rstmid_vld", o_Vld, 1'b1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rstmid_out", {o_busy, o_done, buf_enb, buf_addrb, o_Vld}, '0);
    chk("rstmid_data", {o_Act, o_row, o_col}, '0);
    ready_mode = 0;
    repeat (6) @(posedge CLK);
    #1;
    clear_logs();
    start_job(10'h010, 9'd2, 9'd3, 10'h020, 4'd0, t);
    wait_idle(100, 1'b0);
    chk("rstmid_new_nxfer", xfer_log.size(), 6);

    // Random tiles, random backpressure, ignored start pulses
    for (int k = 0; k < 16; k++) begin
      ready_mode = (k % 3 == 0) ? 0 : 2;
      start_job(10'($urandom), 9'($urandom_range(0, 3)), 9'($urandom_range(0, 6)),
                10'($urandom), 4'($urandom_range(0, 2)), t);
      wait_idle(500, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
